// File: rtl/act_pkg.sv
// ----------------------------------------------------------------------------
// act_pkg
// Shared definitions for the activation datapath: Q3.5 range limits, the
// activation/sigmoid byte types, the per-stage pipeline occupancy encoding and
// the helper that derives the requantisation shift.
// ----------------------------------------------------------------------------
package act_pkg;

  // Q3.5 activation range and fractional width
  localparam logic signed [7:0] Q35_MAX  = 8'sh7F;
  localparam logic signed [7:0] Q35_MIN  = 8'sh80;
  localparam int                Q35_FRAC = 32'sd5;

  // Signed Q3.5 activation (sigmoid input) and unsigned Q0.8 (sigmoid output)
  typedef logic signed [7:0] q35_t;
  typedef logic        [7:0] q08_t;

  // Occupancy of one pipeline register stage
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_st_t;

  // Right shift that moves a value from frac_in to frac_out fractional bits
  function automatic int calc_shift(input int frac_in, input int frac_out);
    return frac_in - frac_out;
  endfunction

endpackage

// File: rtl/rnd_shift_sat.sv
// ----------------------------------------------------------------------------
// rnd_shift_sat
// Combinational round / arithmetic-shift / saturate from an IN_W-bit signed
// value down to signed Q3.5. Rounding adds half an output LSB before the
// arithmetic shift, i.e. round half toward +inf.
//
// Ports:
//   sum  in   IN_W  signed value with SHIFT more fractional bits than x
//   x    out  8     signed Q3.5 result, clipped to [-128, 127]
//   sat  out  1     x was clipped
// ----------------------------------------------------------------------------
module rnd_shift_sat
  import act_pkg::*;
#(
  parameter int IN_W  = 25,
  parameter int SHIFT = 11
) (
  input  logic signed [IN_W-1:0] sum,
  output q35_t                   x,
  output logic                   sat
);

  // One guard bit so adding the rounding constant can never overflow
  localparam int RW = IN_W + 1;
  localparam logic signed [RW-1:0] HALF  = $signed({{(RW-1){1'b0}}, 1'b1} << (SHIFT - 1));
  localparam logic signed [RW-1:0] MAX_V = RW'(Q35_MAX);
  localparam logic signed [RW-1:0] MIN_V = RW'(Q35_MIN);

  logic signed [RW-1:0] rnd_s;
  logic signed [RW-1:0] shr_s;

  // Round, shift and clip to the Q3.5 range
  always_comb begin
    rnd_s = RW'(sum) + HALF;
    shr_s = rnd_s >>> SHIFT;
    if (shr_s > MAX_V) begin
      x   = Q35_MAX;
      sat = 1'b1;
    end else if (shr_s < MIN_V) begin
      x   = Q35_MIN;
      sat = 1'b1;
    end else begin
      x   = shr_s[7:0];
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/act_requant_q35.sv
// ----------------------------------------------------------------------------
// act_requant_q35
// Streaming requantiser feeding the sigmoid stage. Stage 1 registers
// acc_in + cfg_bias at full precision (one extra bit, never overflows);
// stage 2 rounds, shifts and saturates to signed Q3.5 and is the output
// register. Valid/ready on both sides, one element per cycle, two-cycle
// latency when not stalled.
//
// Optional feature macro: ACT_REQUANT_SAT_COUNT_EN
//   defined   -> sat_count counts saturated output handshakes (sticky at
//                16'hFFFF, sat_clr clears and wins over an increment)
//   undefined -> sat_count is tied to zero and sat_clr is ignored
//
// Ports:
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous active-low reset
//   in_valid   in   1      acc_in / in_last valid
//   in_ready   out  1      stage 1 can accept (combinational from out_ready)
//   acc_in     in   ACC_W  signed accumulator, FRAC_IN fractional bits
//   in_last    in   1      last element of vector
//   cfg_bias   in   ACC_W  signed bias, same format as acc_in
//   out_valid  out  1      x_out valid
//   out_ready  in   1      consumer accepts
//   x_out      out  8      signed Q3.5 activation
//   out_last   out  1      in_last aligned with x_out
//   sat_flag   out  1      current x_out was clipped
//   sat_clr    in   1      clear sat_count
//   sat_count  out  16     saturation event count
// ----------------------------------------------------------------------------
module act_requant_q35
  import act_pkg::*;
#(
  parameter int ACC_W    = 24,
  parameter int FRAC_IN  = 16,
  // The sigmoid consumer expects Q3.5; keep equal to Q35_FRAC
  parameter int FRAC_OUT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] acc_in,
  input  logic             in_last,
  input  logic [ACC_W-1:0] cfg_bias,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       x_out,
  output logic             out_last,
  output logic             sat_flag,
  input  logic             sat_clr,
  output logic [15:0]      sat_count
);

  localparam int SHIFT = calc_shift(FRAC_IN, FRAC_OUT);
  localparam int SUM_W = ACC_W + 1;

  // Pipeline occupancy
  stage_st_t s1_st_r, s1_st_nxt_s;
  stage_st_t s2_st_r, s2_st_nxt_s;
  // Holds in_ready low until the first clock edge after reset release
  logic      ready_en_r;

  logic adv1_s;
  logic adv2_s;

  // Stage 1 payload
  logic signed [SUM_W-1:0] s1_sum_r;
  logic                    s1_last_r;

  // Stage 2 payload (output register)
  q35_t x_r;
  logic last_r;
  logic sat_r;

  // Round/shift/saturate result for the element moving into stage 2
  q35_t rnd_x_s;
  logic rnd_sat_s;

  rnd_shift_sat #(
    .IN_W  (SUM_W),
    .SHIFT (SHIFT)
  ) u_rnd_shift_sat (
    .sum (s1_sum_r),
    .x   (rnd_x_s),
    .sat (rnd_sat_s)
  );

  // Handshake decode and next occupancy of both stages
  always_comb begin
    adv2_s   = (s1_st_r == ST_FULL) & ((s2_st_r == ST_EMPTY) | out_ready);
    in_ready = ready_en_r & ((s1_st_r == ST_EMPTY) | adv2_s);
    adv1_s   = in_valid & in_ready;

    s1_st_nxt_s = s1_st_r;
    case (s1_st_r)
      ST_EMPTY: begin
        if (adv1_s) s1_st_nxt_s = ST_FULL;
        else        s1_st_nxt_s = ST_EMPTY;
      end
      ST_FULL: begin
        // A refill in the same cycle as the drain keeps the stage full
        if (adv1_s)      s1_st_nxt_s = ST_FULL;
        else if (adv2_s) s1_st_nxt_s = ST_EMPTY;
        else             s1_st_nxt_s = ST_FULL;
      end
      default: s1_st_nxt_s = ST_EMPTY;
    endcase

    s2_st_nxt_s = s2_st_r;
    case (s2_st_r)
      ST_EMPTY: begin
        if (adv2_s) s2_st_nxt_s = ST_FULL;
        else        s2_st_nxt_s = ST_EMPTY;
      end
      ST_FULL: begin
        if (adv2_s)         s2_st_nxt_s = ST_FULL;
        else if (out_ready) s2_st_nxt_s = ST_EMPTY;
        else                s2_st_nxt_s = ST_FULL;
      end
      default: s2_st_nxt_s = ST_EMPTY;
    endcase
  end

  // Occupancy state registers and post-reset ready enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_st_r    <= ST_EMPTY;
      s2_st_r    <= ST_EMPTY;
      ready_en_r <= 1'b0;
    end else begin
      s1_st_r    <= s1_st_nxt_s;
      s2_st_r    <= s2_st_nxt_s;
      ready_en_r <= 1'b1;
    end
  end

  // Stage 1: bias add at full precision; bias is sampled with the element
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_sum_r  <= '0;
      s1_last_r <= 1'b0;
    end else if (adv1_s) begin
      s1_sum_r  <= SUM_W'($signed(acc_in)) + SUM_W'($signed(cfg_bias));
      s1_last_r <= in_last;
    end else begin
      s1_sum_r  <= s1_sum_r;
      s1_last_r <= s1_last_r;
    end
  end

  // Stage 2: output register, holds while the consumer stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_r    <= 8'sh00;
      last_r <= 1'b0;
      sat_r  <= 1'b0;
    end else if (adv2_s) begin
      x_r    <= rnd_x_s;
      last_r <= s1_last_r;
      sat_r  <= rnd_sat_s;
    end else begin
      x_r    <= x_r;
      last_r <= last_r;
      sat_r  <= sat_r;
    end
  end

  assign out_valid = (s2_st_r == ST_FULL);
  assign x_out     = x_r;
  assign out_last  = last_r;
  assign sat_flag  = sat_r;

`ifdef ACT_REQUANT_SAT_COUNT_EN
  logic [15:0] sat_cnt_r;

  // Saturated-handshake counter; clear wins, sticks at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_cnt_r <= 16'h0000;
    end else if (sat_clr) begin
      sat_cnt_r <= 16'h0000;
    end else if (out_valid && out_ready && sat_r && (sat_cnt_r != 16'hFFFF)) begin
      sat_cnt_r <= sat_cnt_r + 16'h0001;
    end else begin
      sat_cnt_r <= sat_cnt_r;
    end
  end

  assign sat_count = sat_cnt_r;
`else
  logic unused_sat_clr_s;
  assign unused_sat_clr_s = sat_clr;
  assign sat_count        = 16'h0000;
`endif

endmodule

// File: tb/tb_act_requant_q35.sv
// ----------------------------------------------------------------------------
// tb_act_requant_q35
// Scoreboard bench: every accepted input pushes the value predicted by an
// arithmetic reference model; a monitor pops and compares on every output
// handshake and also checks hold stability, in_ready and sat_count.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_act_requant_q35;

  localparam int ACC_W    = 24;
  localparam int FRAC_IN  = 16;
  localparam int FRAC_OUT = 5;
  localparam int SHIFT    = FRAC_IN - FRAC_OUT;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] acc_in;
  logic             in_last;
  logic [ACC_W-1:0] cfg_bias;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       x_out;
  logic             out_last;
  logic             sat_flag;
  logic             sat_clr;
  logic [15:0]      sat_count;

  act_requant_q35 #(
    .ACC_W    (ACC_W),
    .FRAC_IN  (FRAC_IN),
    .FRAC_OUT (FRAC_OUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .acc_in    (acc_in),
    .in_last   (in_last),
    .cfg_bias  (cfg_bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .out_last  (out_last),
    .sat_flag  (sat_flag),
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x;
    logic       last;
    logic       sat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_cnt = 16'h0;
  logic        held_v = 1'b0;
  logic [7:0]  held_x;
  logic        held_l;
  logic        held_s;
  logic        m_hs;
  exp_t        m_e;
  logic        rnd_done;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: real-valued sum scaled to output LSBs, rounded half up, clipped
  function automatic exp_t model(input logic signed [ACC_W-1:0] a,
                                 input logic signed [ACC_W-1:0] b,
                                 input logic l);
    longint step;
    longint v;
    longint q;
    exp_t   e;
    step = longint'(1) << SHIFT;
    v    = longint'(a) + longint'(b) + step / 2;
    if (v >= 0) q = v / step;
    else        q = -((-v + step - 1) / step);
    e.last = l;
    if (q > 127) begin
      e.x = 8'h7F; e.sat = 1'b1;
    end else if (q < -128) begin
      e.x = 8'h80; e.sat = 1'b1;
    end else begin
      e.x = 8'(q); e.sat = 1'b0;
    end
    return e;
  endfunction

  // Monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      exp_cnt = 16'h0;
      held_v  = 1'b0;
    end else begin
      chk("in_ready", in_ready, !(sb_q.size() == 2 && !out_ready));
      chk("sat_count", sat_count, exp_cnt);
      if (held_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_x", x_out, held_x);
        chk("hold_last", out_last, held_l);
        chk("hold_sat", sat_flag, held_s);
      end
      m_hs  = out_valid && out_ready;
      m_e   = '0;
      if (m_hs) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got x_out=%h with nothing expected at %0t", x_out, $time);
        end else begin
          m_e = sb_q.pop_front();
          chk("x_out", x_out, m_e.x);
          chk("out_last", out_last, m_e.last);
          chk("sat_flag", sat_flag, m_e.sat);
        end
      end
`ifdef ACT_REQUANT_SAT_COUNT_EN
      if (sat_clr) exp_cnt = 16'h0;
      else if (m_hs && m_e.sat && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h1;
`endif
      if (in_valid && in_ready) sb_q.push_back(model(acc_in, cfg_bias, in_last));
      held_v = out_valid && !out_ready;
      held_x = x_out;
      held_l = out_last;
      held_s = sat_flag;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic send(input logic signed [ACC_W-1:0] a, input logic l);
    int n;
    n        = 0;
    in_valid = 1'b1;
    acc_in   = a;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stuck at 0, required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d outputs outstanding, required 0", sb_q.size());
    end
  endtask

  function automatic logic signed [ACC_W-1:0] rnd_acc();
    int t;
    case ($urandom_range(0, 2))
      0:       t = int'($urandom_range(0, 32'h00FF_FFFF)) - 32'sh0080_0000;
      1:       t = int'($urandom_range(0, 524287)) - 262144;
      default: t = int'($urandom_range(0, 8191)) - 4096;
    endcase
    return ACC_W'(t);
  endfunction

  logic signed [ACC_W-1:0] dir_acc  [7] = '{24'sd65536, 24'sd1024, -24'sd1024, -24'sd1025,
                                            24'sd262144, -24'sd327680, 24'sd0};
  logic signed [ACC_W-1:0] dir_bias [7] = '{24'sd0, 24'sd0, 24'sd0, 24'sd0,
                                            24'sd0, 24'sd0, 24'sd32768};

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    acc_in    = '0;
    in_last   = 1'b0;
    cfg_bias  = '0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    rnd_done  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_x_out", x_out, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 chk("in_ready_before_edge", in_ready, 0);
    @(posedge clk);
    #1 chk("in_ready_after_edge", in_ready, 1);

    // Directed points: unity, rounding boundaries, saturation, bias
    for (int i = 0; i < 7; i++) begin
      cfg_bias = dir_bias[i];
      send(dir_acc[i], 1'(i % 2));
      chk("latency_s1", out_valid, 0);
      @(posedge clk);
      #1 chk("latency_s2", out_valid, 1);
      wait_empty();
    end
    cfg_bias = '0;

    // Backpressure: 8 values, random out_ready with a 5-cycle stall
    fork
      begin
        for (int i = 0; i < 8; i++) send(rnd_acc(), 1'(i == 7));
      end
      begin
        for (int c = 0; c < 30; c++) begin
          out_ready = (c >= 2 && c < 7) ? 1'b0 : 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_empty();

    // Random traffic with changing bias and random consumer stalls
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 7) == 0)
            cfg_bias = ACC_W'(int'($urandom_range(0, 524287)) - 262144);
          send(rnd_acc(), 1'($urandom_range(0, 1)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 9) < 7);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_empty();
    cfg_bias = '0;

    // Clear coinciding with a saturating handshake
    sat_clr = 1'b1;
    send(24'sd262144, 1'b0);
    wait_empty();
    @(posedge clk);
    #1 chk("sat_count_cleared", sat_count, 0);
    sat_clr = 1'b0;

    // Reset with two elements in flight
    out_ready = 1'b0;
    send(24'sd65536, 1'b1);
    send(-24'sd65536, 1'b1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_x_out", x_out, 0);
    chk("midrst_out_last", out_last, 0);
    chk("midrst_sat_flag", sat_flag, 0);
    chk("midrst_in_ready", in_ready, 0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    out_ready = 1'b1;
    #1 chk("midrst_ready_before_edge", in_ready, 0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1 chk("no_stale_output", out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
